// File: rtl/bus_pkg.sv
// Shared types and widths for the serial-bus transaction interface.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StWaitAck,
    StResp
  } bus_init_state_e;

  typedef struct packed {
    logic                  rw;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating cycle counter that flags the last allowed cycle of a bus transaction.
// TimeoutCycles = 0 removes the counter and never expires.
module bus_timeout_ctr #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TimeoutCycles > 0) begin : g_timer
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count active cycles; hold at the last value so a late state change cannot wrap it.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != CntLast)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = enable && (cnt_q == CntLast);
  end else begin : g_no_timer
    assign expired = 1'b0;
  end

endmodule

// File: rtl/bus_initiator.sv
// Initiator end of the 16-bit address / 8-bit data bus. One client request at a time is
// captured, presented to the target, and completed by the target ack or by a timeout.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned SPLIT_WRITE    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [BUS_ADDR_W-1:0] req_addr,
  input  logic [BUS_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [BUS_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [BUS_ADDR_W-1:0] init_addr_out,
  output logic                  init_addr_out_valid,
  output logic [BUS_DATA_W-1:0] init_data_out,
  output logic                  init_data_out_valid,
  output logic                  init_rw,
  input  logic [BUS_DATA_W-1:0] init_data_in,
  input  logic                  init_data_in_valid,
  input  logic                  init_ack,
  input  logic                  init_ready
);

  localparam logic SplitEn = (SPLIT_WRITE != 0);

  bus_init_state_e       state_q, state_d;
  bus_req_t              req_q, req_d;
  logic [BUS_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  active;
  logic                  tmr_clear;
  logic                  tmr_expired;

  assign active    = (state_q == StAddr) || (state_q == StWdata) || (state_q == StWaitAck);
  // Holding the timer clear while idle means it starts from zero on the first ADDR cycle.
  assign tmr_clear = (state_q == StIdle);

  bus_timeout_ctr #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (active),
    .expired(tmr_expired)
  );

  // Next-state, request capture and response update.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          req_d.rw    = req_rw;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          state_d     = StAddr;
        end
      end
      StAddr: begin
        if (tmr_expired) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (init_ready) begin
          state_d = (req_q.rw && SplitEn) ? StWdata : StWaitAck;
        end
      end
      StWdata: begin
        if (tmr_expired) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        // An ack on the final allowed cycle still counts as a normal completion.
        if (init_ack) begin
          state_d = StResp;
          if (req_q.rw) begin
            rdata_d = '0;
            err_d   = 1'b0;
          end else if (init_data_in_valid) begin
            rdata_d = init_data_in;
            err_d   = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end else if (tmr_expired) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, captured request and response registers; reset aborts silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign init_addr_out       = active ? req_q.addr : '0;
  assign init_rw             = active && req_q.rw;
  assign init_data_out       = (active && req_q.rw) ? req_q.wdata : '0;
  assign init_addr_out_valid = (state_q == StAddr) && init_ready;
  assign init_data_out_valid = ((state_q == StAddr) && init_ready && req_q.rw && !SplitEn) ||
                               (state_q == StWdata);

endmodule

// File: tb/tb_bus_initiator.sv
// Randomized bench for bus_initiator: lane 0 unsplit with an 8-cycle timeout, lane 1 split
// writes with a 16-cycle timeout. Each lane has a reactive target and a transaction model.
module tb_bus_initiator;

  localparam int NumTxn = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int  To    = (g == 0) ? 8 : 16;
    localparam bit  Split = (g == 1);

    logic        rst_n, req_valid, req_ready, req_rw, rsp_valid, rsp_err;
    logic [15:0] req_addr, init_addr_out;
    logic [7:0]  req_wdata, rsp_rdata, init_data_out, init_data_in;
    logic        init_addr_out_valid, init_data_out_valid, init_rw;
    logic        init_data_in_valid, init_ack, init_ready;
    logic        done = 1'b0;

    int          tgt_lat;
    logic        tgt_noack, tgt_malformed, tgt_stray;
    logic [7:0]  tgt_mem   [256];
    logic [7:0]  model_mem [256];

    bus_initiator #(
      .SPLIT_WRITE   (g),
      .TIMEOUT_CYCLES(To)
    ) u_dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_rw             (req_rw),
      .req_addr           (req_addr),
      .req_wdata          (req_wdata),
      .rsp_valid          (rsp_valid),
      .rsp_rdata          (rsp_rdata),
      .rsp_err            (rsp_err),
      .init_addr_out      (init_addr_out),
      .init_addr_out_valid(init_addr_out_valid),
      .init_data_out      (init_data_out),
      .init_data_out_valid(init_data_out_valid),
      .init_rw            (init_rw),
      .init_data_in       (init_data_in),
      .init_data_in_valid (init_data_in_valid),
      .init_ack           (init_ack),
      .init_ready         (init_ready)
    );

    task automatic check_idle(input string tag);
      check_eq({tag, " req_ready"}, 32'(req_ready), 32'd1);
      check_eq({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, " addr_valid"}, 32'(init_addr_out_valid), 32'd0);
      check_eq({tag, " data_valid"}, 32'(init_data_out_valid), 32'd0);
      check_eq({tag, " addr_out"}, 32'(init_addr_out), 32'd0);
      check_eq({tag, " data_out"}, 32'(init_data_out), 32'd0);
      check_eq({tag, " rw"}, 32'(init_rw), 32'd0);
      check_eq({tag, " rdata"}, 32'(rsp_rdata), 32'd0);
      check_eq({tag, " err"}, 32'(rsp_err), 32'd0);
    endtask

    // Target: samples strobes mid-cycle, answers with a registered ack tgt_lat cycles later.
    initial begin : target
      int          pend;
      logic        fire, pend_dv;
      logic [7:0]  pend_data;
      logic [15:0] wr_addr;
      pend = 0; pend_dv = 1'b0; pend_data = 8'h00; wr_addr = 16'h0000;
      init_ack = 1'b0; init_data_in = 8'h00; init_data_in_valid = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pend = 0;
        end else begin
          if (init_addr_out_valid) wr_addr = init_addr_out;
          if (init_data_out_valid) begin
            tgt_mem[wr_addr[7:0]] = init_data_out;
            pend = tgt_lat; pend_dv = 1'b0; pend_data = 8'h00;
          end else if (init_addr_out_valid && !init_rw) begin
            pend = tgt_lat; pend_dv = !tgt_malformed; pend_data = tgt_mem[init_addr_out[7:0]];
          end
        end
        @(posedge clk);
        #1;
        fire = 1'b0;
        if (pend > 0) begin
          pend--;
          fire = (pend == 0) && !tgt_noack;
        end
        init_ack           = fire || tgt_stray;
        init_data_in       = fire ? pend_data : 8'($urandom);
        init_data_in_valid = fire ? pend_dv : 1'($urandom_range(0, 1));
      end
    end

    initial begin : drive
      int          s, lat, strobe_k, ka, done_k, k_rsp, gap;
      logic        rw, noack, mal, hold, hold_prev, exp_err, prev_err;
      logic [15:0] addr;
      logic [7:0]  wdata, exp_rdata, prev_rdata;
      rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
      init_ready = 1'b0; tgt_lat = 1; tgt_noack = 1'b0; tgt_malformed = 1'b0; tgt_stray = 1'b0;
      for (int i = 0; i < 256; i++) begin
        tgt_mem[i]   = 8'($urandom);
        model_mem[i] = tgt_mem[i];
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle($sformatf("L%0d reset", g));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold_prev = 1'b0; prev_err = 1'b0; prev_rdata = 8'h00;

      for (int t = 0; t < NumTxn; t++) begin
        rw    = 1'($urandom_range(0, 1));
        addr  = 16'($urandom);
        wdata = 8'($urandom);
        s     = int'($urandom_range(0, 3));
        lat   = int'($urandom_range(1, 4));
        noack = ($urandom_range(0, 7) == 0);
        mal   = !rw && ($urandom_range(0, 5) == 0);
        hold  = ($urandom_range(0, 3) == 0);
        gap   = int'($urandom_range(0, 2));
        if (t <= 1) begin
          rw = (t == 0); addr = Split ? 16'h00FF : 16'h0012; wdata = Split ? 8'h3C : 8'hA5;
          s = 0; lat = 1; noack = 1'b0; mal = 1'b0; hold = 1'b0;
        end else if (t == 2) begin
          rw = 1'b0; s = 0; noack = 1'b1; mal = 1'b0;
        end else if (t == 3) begin
          rw = 1'b1; s = 3; lat = 4; noack = 1'b0; hold = 1'b1;
        end

        if (!hold_prev) begin
          tgt_stray = (gap > 0);
          for (int c = 0; c < gap + 2; c++) begin
            if (c == gap) tgt_stray = 1'b0;
            @(negedge clk);
            check_eq($sformatf("L%0d t%0d idle req_ready", g, t), 32'(req_ready), 32'd1);
            check_eq($sformatf("L%0d t%0d idle rsp_valid", g, t), 32'(rsp_valid), 32'd0);
            check_eq($sformatf("L%0d t%0d idle addr_valid", g, t),
                     32'(init_addr_out_valid), 32'd0);
            check_eq($sformatf("L%0d t%0d held rdata", g, t), 32'(rsp_rdata), 32'(prev_rdata));
            check_eq($sformatf("L%0d t%0d held err", g, t), 32'(rsp_err), 32'(prev_err));
            @(posedge clk);
            #1;
          end
        end

        // Accept cycle T.
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
        init_ready = 1'($urandom_range(0, 1));
        tgt_lat = lat; tgt_noack = noack; tgt_malformed = mal;
        @(negedge clk);
        check_eq($sformatf("L%0d t%0d accept req_ready", g, t), 32'(req_ready), 32'd1);
        check_eq($sformatf("L%0d t%0d accept held rdata", g, t), 32'(rsp_rdata),
                 32'(prev_rdata));
        @(posedge clk);
        #1;

        // Transaction-level prediction; k counts cycles from the first address cycle.
        strobe_k = s + ((Split && rw) ? 1 : 0);
        ka       = strobe_k + lat;
        if (!noack && ka <= To - 1) begin
          done_k    = ka;
          exp_err   = !rw && mal;
          exp_rdata = (rw || mal) ? 8'h00 : model_mem[addr[7:0]];
        end else begin
          done_k    = To - 1;
          exp_err   = 1'b1;
          exp_rdata = 8'h00;
        end
        if (rw) model_mem[addr[7:0]] = wdata;
        k_rsp = done_k + 1;

        for (int k = 0; k <= k_rsp; k++) begin
          req_valid = hold; req_rw = 1'($urandom); req_addr = 16'($urandom);
          req_wdata = 8'($urandom);
          init_ready = (k < s) ? 1'b0 : (k == s) ? 1'b1 : 1'($urandom_range(0, 1));
          @(negedge clk);
          check_eq($sformatf("L%0d t%0d k%0d addr_valid", g, t, k),
                   32'(init_addr_out_valid), 32'(k == s));
          check_eq($sformatf("L%0d t%0d k%0d data_valid", g, t, k),
                   32'(init_data_out_valid), 32'(rw && (k == strobe_k)));
          check_eq($sformatf("L%0d t%0d k%0d rsp_valid", g, t, k), 32'(rsp_valid),
                   32'(k == k_rsp));
          check_eq($sformatf("L%0d t%0d k%0d req_ready", g, t, k), 32'(req_ready), 32'd0);
          if (k == s) begin
            check_eq($sformatf("L%0d t%0d addr_out", g, t), 32'(init_addr_out), 32'(addr));
            check_eq($sformatf("L%0d t%0d rw", g, t), 32'(init_rw), 32'(rw));
            check_eq($sformatf("L%0d t%0d data_out", g, t), 32'(init_data_out),
                     32'(rw ? wdata : 8'h00));
          end
          if (Split && rw && k == strobe_k) begin
            check_eq($sformatf("L%0d t%0d split data_out", g, t), 32'(init_data_out),
                     32'(wdata));
          end
          if (k == k_rsp) begin
            check_eq($sformatf("L%0d t%0d rsp_rdata", g, t), 32'(rsp_rdata), 32'(exp_rdata));
            check_eq($sformatf("L%0d t%0d rsp_err", g, t), 32'(rsp_err), 32'(exp_err));
          end
          @(posedge clk);
          #1;
        end
        hold_prev = hold; prev_rdata = exp_rdata; prev_err = exp_err;
      end
      req_valid = 1'b0;

      // Reset during WAIT_ACK: no response afterwards, all outputs back to idle values.
      tgt_noack = 1'b1; tgt_lat = 1; req_rw = 1'b0; req_addr = 16'($urandom);
      req_valid = 1'b1; init_ready = 1'b1;
      @(negedge clk);
      check_eq($sformatf("L%0d rst accept req_ready", g), 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_eq($sformatf("L%0d rst wait_ack req_ready", g), 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_idle($sformatf("L%0d mid reset", g));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        check_eq($sformatf("L%0d post reset c%0d rsp_valid", g, c), 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
      end
      tgt_noack = 1'b0;
      done = 1'b1;
    end
  end

  initial begin : finish_ctl
    for (int c = 0; c < 50000 && !(g_lane[0].done && g_lane[1].done); c++) @(posedge clk);
    check_eq("lanes_done", 32'({g_lane[0].done, g_lane[1].done}), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
